// File: rtl/comparador_umbral_multicanal.sv
// comparador_umbral_multicanal
//   Multi-channel threshold comparator for the millisecond counter datapath.
//   A free-running count value (valor) is compared every cycle against CANALES
//   programmable thresholds. Each channel raises a registered one-cycle pulse
//   on the rising edge of its match and keeps a sticky flag until cleared.
//
//   Optional feature macro: MODO_GE_EN
//     defined   : per-channel mode register, modo_dato selects EQ (0) / GE (1)
//     undefined : every channel is equality-only, modo_dato is ignored
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   valor        in   [ANCHO]    count value, sampled each clk
//   habilitar    in   global enable for pulses and flag setting
//   umbral_wr    in   threshold write strobe
//   umbral_sel   in   [SEL_W]    channel index for the write
//   umbral_dato  in   [ANCHO]    threshold value to write
//   modo_dato    in   mode for the written channel (MODO_GE_EN only)
//   limpiar      in   [CANALES]  per-channel sticky-flag clear, level
//   coincidencia out  [CANALES]  one-cycle match pulse per channel
//   bandera      out  [CANALES]  sticky match flag per channel
//   cualquiera   out  OR of bandera (registered alongside it)

// One compare channel: threshold register, edge detector, pulse and flag.
module comparador_canal #(
  parameter int ANCHO = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] valor_i,
  input  logic             habilitar_i,
  input  logic             wr_i,
  input  logic [ANCHO-1:0] dato_i,
`ifdef MODO_GE_EN
  input  logic             modo_i,
`endif
  input  logic             limpiar_i,
  output logic             coin_o,
  output logic             band_o,
  output logic             band_d_o
);
  logic [ANCHO-1:0] umbral_q;
  logic             prev_q, coin_q, band_q;
  logic             match, pulso_d, band_d;

`ifdef MODO_GE_EN
  logic modo_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    modo_q <= 1'b0;
    else if (wr_i) modo_q <= modo_i;
  end
  assign match = modo_q ? (valor_i >= umbral_q) : (valor_i == umbral_q);
`else
  assign match = (valor_i == umbral_q);
`endif

  assign pulso_d  = habilitar_i & match & ~prev_q;
  // A new pulse wins over a clear arriving in the same cycle.
  assign band_d   = (band_q & ~limpiar_i) | pulso_d;
  assign band_d_o = band_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      umbral_q <= {ANCHO{1'b1}};
      prev_q   <= 1'b0;
      coin_q   <= 1'b0;
      band_q   <= 1'b0;
    end else begin
      // prev tracks match even while disabled, so re-enabling on a held
      // match does not fire. A threshold write re-arms the channel.
      prev_q <= wr_i ? 1'b0 : match;
      coin_q <= pulso_d;
      band_q <= band_d;
      if (wr_i) umbral_q <= dato_i;
    end
  end

  assign coin_o = coin_q;
  assign band_o = band_q;
endmodule

module comparador_umbral_multicanal #(
  parameter int ANCHO   = 19,
  parameter int CANALES = 4,
  parameter int SEL_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ANCHO-1:0]   valor,
  input  logic               habilitar,
  input  logic               umbral_wr,
  input  logic [SEL_W-1:0]   umbral_sel,
  input  logic [ANCHO-1:0]   umbral_dato,
  input  logic               modo_dato,
  input  logic [CANALES-1:0] limpiar,
  output logic [CANALES-1:0] coincidencia,
  output logic [CANALES-1:0] bandera,
  output logic               cualquiera
);
  logic [CANALES-1:0] band_d;
  logic               cualquiera_q;

`ifndef MODO_GE_EN
  // Pin kept for compatibility; nothing consumes it in the EQ-only build.
  logic unused_modo_dato;
  assign unused_modo_dato = modo_dato;
`endif

  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    // Out-of-range umbral_sel matches no channel, so the write is dropped.
    logic wr_hit;
    assign wr_hit = umbral_wr & (umbral_sel == SEL_W'(i));

    comparador_canal #(.ANCHO(ANCHO)) u_canal (
      .clk         (clk),
      .rst_n       (rst_n),
      .valor_i     (valor),
      .habilitar_i (habilitar),
      .wr_i        (wr_hit),
      .dato_i      (umbral_dato),
`ifdef MODO_GE_EN
      .modo_i      (modo_dato),
`endif
      .limpiar_i   (limpiar[i]),
      .coin_o      (coincidencia[i]),
      .band_o      (bandera[i]),
      .band_d_o    (band_d[i])
    );
  end

  // Built from next-state flags so it lines up with bandera.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cualquiera_q <= 1'b0;
    else        cualquiera_q <= |band_d;
  end

  assign cualquiera = cualquiera_q;
endmodule

// File: tb/tb_comparador_umbral_multicanal.sv
module tb_comparador_umbral_multicanal;
  localparam int W = 19;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] valor = '0;
  logic         habilitar = 1'b0;
  logic         umbral_wr = 1'b0;
  logic [1:0]   umbral_sel = '0;
  logic [W-1:0] umbral_dato = '0;
  logic         modo_dato = 1'b0;
  logic [C-1:0] limpiar = '0;
  logic [C-1:0] coincidencia, bandera;
  logic         cualquiera;

  int checks = 0;
  int failures = 0;

  comparador_umbral_multicanal #(.ANCHO(W), .CANALES(C), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .valor(valor), .habilitar(habilitar),
    .umbral_wr(umbral_wr), .umbral_sel(umbral_sel), .umbral_dato(umbral_dato),
    .modo_dato(modo_dato), .limpiar(limpiar), .coincidencia(coincidencia),
    .bandera(bandera), .cualquiera(cualquiera)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0] c;
    logic [C-1:0] b;
    logic         a;
    string        tag;
  } exp_t;
  exp_t sb[$];

  // Behavioural reference state
  logic [W-1:0] um_m [C];
  logic         md_m [C];
  logic [C-1:0] pv_m, bd_m;

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      um_m[i] = '1;
      md_m[i] = 1'b0;
    end
    pv_m = '0;
    bd_m = '0;
  endtask

  task automatic chk(input string tag, input logic [C-1:0] got, input logic [C-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Predict the outcome of the current inputs, push it, clock, pop and compare.
  task automatic step(input string tag);
    exp_t e, o;
    logic m;
    e.tag = tag;
    e.c = '0;
    for (int i = 0; i < C; i++) begin
      if (md_m[i]) m = (valor >= um_m[i]);
      else         m = (valor == um_m[i]);
      e.c[i]  = habilitar & m & ~pv_m[i];
      bd_m[i] = (bd_m[i] & ~limpiar[i]) | e.c[i];
      pv_m[i] = (umbral_wr && umbral_sel == 2'(i)) ? 1'b0 : m;
    end
    if (umbral_wr && int'(umbral_sel) < C) begin
      um_m[umbral_sel] = umbral_dato;
`ifdef MODO_GE_EN
      md_m[umbral_sel] = modo_dato;
`else
      md_m[umbral_sel] = 1'b0;
`endif
    end
    e.b = bd_m;
    e.a = |bd_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk({o.tag, "/coin"}, coincidencia, o.c);
    chk({o.tag, "/band"}, bandera, o.b);
    chk({o.tag, "/any"}, {3'b0, cualquiera}, {3'b0, o.a});
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset/coin", coincidencia, 4'h0);
    chk("reset/band", bandera, 4'h0);
    chk("reset/any", {3'b0, cualquiera}, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: thresholds reset to all ones
    habilitar = 1'b1;
    valor = 19'h7FFFF;
    step("t1_allones");
    chk("t1_pulse_all", coincidencia, 4'hF);
    step("t1_hold");
    chk("t1_single", coincidencia, 4'h0);
    valor = 0; limpiar = 4'hF;
    step("t1_clear");
    limpiar = 4'h0;

    // 2: EQ on channel 1
    umbral_wr = 1'b1; umbral_sel = 2'd1; umbral_dato = 19'd1000; modo_dato = 1'b0;
    step("t2_write");
    umbral_wr = 1'b0;
    for (int v = 998; v <= 1003; v++) begin
      valor = 19'(v);
      step("t2_ramp");
      if (v == 1000) chk("t2_pulse1000", coincidencia, 4'b0010);
    end
    chk("t2_flag_held", bandera, 4'b0010);

    // 3: held match gives one pulse; clear drops the flag
    valor = 19'd1000;
    for (int k = 0; k < 5; k++) step("t3_hold");
    limpiar = 4'b0010;
    step("t3_clear");
    chk("t3_flag_cleared", bandera, 4'b0000);
    limpiar = 4'h0;

    // enable gating: no pulse while disabled, none on re-enable mid-match
    valor = 0; step("en_away");
    habilitar = 1'b0; valor = 19'd1000; step("en_off_match");
    chk("en_off_nopulse", coincidencia, 4'h0);
    habilitar = 1'b1; step("en_reenable");
    chk("en_reenable_nopulse", coincidencia, 4'h0);

    // 4: pulse and clear collide on channel 2
    umbral_wr = 1'b1; umbral_sel = 2'd2; umbral_dato = 19'd50; valor = 0;
    step("t4_write");
    umbral_wr = 1'b0; valor = 19'd50; limpiar = 4'b0100;
    step("t4_collide");
    chk("t4_set_wins", bandera & 4'b0100, 4'b0100);
    step("t4_clear_after");
    limpiar = 4'h0;

    // 5: re-arm by rewriting a threshold under a constant value
    valor = 19'd500;
    umbral_wr = 1'b1; umbral_sel = 2'd0; umbral_dato = 19'd500;
    step("t5_write");
    chk("t5_no_early", coincidencia & 4'b0001, 4'b0000);
    umbral_wr = 1'b0;
    step("t5_arm");
    chk("t5_pulse", coincidencia, 4'b0001);
    step("t5_hold");
    umbral_wr = 1'b1;
    step("t5_rewrite");
    umbral_wr = 1'b0;
    step("t5_rearm");
    chk("t5_pulse_again", coincidencia, 4'b0001);

    // 6: GE mode (EQ-only build: pulse only on equality)
    umbral_wr = 1'b1; umbral_sel = 2'd3; umbral_dato = 19'd200; modo_dato = 1'b1;
    valor = 19'd199;
    step("t6_write");
    umbral_wr = 1'b0; modo_dato = 1'b0;
    step("t6_199");
    valor = 19'd250; step("t6_250");
`ifdef MODO_GE_EN
    chk("t6_ge_pulse", coincidencia, 4'b1000);
`else
    chk("t6_eq_nopulse", coincidencia, 4'b0000);
`endif
    valor = 19'd251; step("t6_251");
    valor = 19'd0;   step("t6_wrap");
    valor = 19'd200; step("t6_200");
    chk("t6_pulse200", coincidencia, 4'b1000);

    // invalid-looking writes are all in range at CANALES=4; mid-run reset
    valor = 19'd50; limpiar = 4'h0; step("rst_pre");
    #2; rst_n = 1'b0; #1;
    chk("midrst/coin", coincidencia, 4'h0);
    chk("midrst/band", bandera, 4'h0);
    chk("midrst/any", {3'b0, cualquiera}, 4'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    valor = 19'd1000; step("midrst_lost");
    chk("midrst_no_old_thr", coincidencia, 4'h0);
    valor = 19'h7FFFF; step("midrst_allones");
    chk("midrst_pulse_all", coincidencia, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
